matrix_scan_controller: RTL and testbench

- Sequencer for the 35-output (7 rows x 5 columns) LED-matrix demultiplexer.
- Holds a 35-bit frame, scans it pixel by pixel, and drives that demux's IPT and SEL0..SEL5 inputs. Only one LED is lit at a time; persistence of vision shows the full image.
- Double-buffered: a new frame is accepted over a valid/ready handshake while the current frame keeps scanning. It becomes active only at a frame boundary.

---
 rtl/matrix_scan_pkg.sv | 26 ++
 rtl/matrix_scan_controller_scan_dwell_timer.sv | 37 +++
 rtl/matrix_scan_controller.sv | 177 +++++++++++++++++
 tb/tb_matrix_scan_controller.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/matrix_scan_pkg.sv
// Shared constants, state encoding and code helpers for the 7x5 LED matrix scanner.
package matrix_scan_pkg;

    localparam int N_ROWS = 7;
    localparam int N_COLS = 5;
    localparam int N_PIX  = 35;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        DRIVE = 2'd2
    } state_e;

    // Demux select codes are 1-based; the all-zero code selects nothing.
    function automatic logic [2:0] sel_code(input logic [2:0] index);
        return index + 3'd1;
    endfunction

    function automatic logic [15:0] bright_threshold(input logic [3:0] bright,
                                                     input logic [15:0] dwell);
        logic [20:0] prod;
        prod = (21'(bright) + 21'd1) * 21'(dwell);
        return 16'(prod >> 4);
    endfunction

endpackage

// File: rtl/matrix_scan_controller_scan_dwell_timer.sv
// Per-pixel dwell counter: cleared by load, advanced by run, flags the final dwell cycle.
module scan_dwell_timer #(
    parameter int unsigned DWELL_CYCLES = 1000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        load_i,
    input  logic        run_i,
    output logic [15:0] count_o,
    output logic        last_o
);

    logic [15:0] count_q, count_d;

    // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = '0;
        end else if (run_i) begin
            count_d = count_q + 16'd1;
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign last_o  = (count_q == 16'(DWELL_CYCLES - 1));

endmodule

// File: rtl/matrix_scan_controller.sv
// Row-major scan sequencer for the 7x5 LED demux with a double-buffered frame.
// Define MATRIX_SCAN_BRIGHTNESS_EN to add the BRIGHT[3:0] on-time control input.
module matrix_scan_controller
    import matrix_scan_pkg::*;
#(
    parameter int unsigned DWELL_CYCLES = 1000
) (
    input  logic        CLK,
    input  logic        RST,
`ifdef MATRIX_SCAN_BRIGHTNESS_EN
    input  logic [3:0]  BRIGHT,
`endif
    input  logic        ENABLE,
    input  logic        LOAD_VALID,
    input  logic [34:0] LOAD_DATA,
    output logic        LOAD_READY,
    output logic        IPT,
    output logic        SEL0,
    output logic        SEL1,
    output logic        SEL2,
    output logic        SEL3,
    output logic        SEL4,
    output logic        SEL5,
    output logic        FRAME_DONE
);

    state_e      state_q, state_d;
    logic [5:0]  idx_q, idx_d;
    logic [2:0]  row_q, row_d, col_q, col_d;
    logic [34:0] active_q, active_d, shadow_q, shadow_d;
    logic        shadow_full_q, shadow_full_d;
    logic        ipt_q, ipt_d, frame_done_q, frame_done_d;
    logic [5:0]  sel_q, sel_d;
    logic        timer_load, timer_run, timer_last, boundary;
    logic [15:0] dwell_count, on_threshold;

    scan_dwell_timer #(.DWELL_CYCLES(DWELL_CYCLES)) u_timer (
        .clk_i   (CLK),
        .rst_i   (RST),
        .load_i  (timer_load),
        .run_i   (timer_run),
        .count_o (dwell_count),
        .last_o  (timer_last)
    );

`ifdef MATRIX_SCAN_BRIGHTNESS_EN
    logic [3:0] bright_q, bright_d;
    assign on_threshold = bright_threshold(bright_q, 16'(DWELL_CYCLES));
`else
    assign on_threshold = 16'(DWELL_CYCLES);
`endif

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        row_d         = row_q;
        col_d         = col_q;
        active_d      = active_q;
        shadow_d      = shadow_q;
        shadow_full_d = shadow_full_q;
        timer_load    = 1'b0;
        timer_run     = 1'b0;
        boundary      = 1'b0;
`ifdef MATRIX_SCAN_BRIGHTNESS_EN
        bright_d      = bright_q;
`endif
        // A load needs an empty shadow and a swap needs a full one, so they never collide.
        if (LOAD_VALID && !shadow_full_q) begin
            shadow_d      = LOAD_DATA;
            shadow_full_d = 1'b1;
        end
        case (state_q)
            IDLE: begin
                if (shadow_full_q) begin
                    active_d      = shadow_q;
                    shadow_full_d = 1'b0;
                end
                if (ENABLE) begin
                    state_d = BLANK;
`ifdef MATRIX_SCAN_BRIGHTNESS_EN
                    bright_d = BRIGHT;
`endif
                end
            end
            BLANK, DRIVE: begin
                if (!ENABLE) begin
                    state_d = IDLE;
                    idx_d   = '0;
                    row_d   = '0;
                    col_d   = '0;
                end else if (state_q == BLANK) begin
                    state_d    = DRIVE;
                    timer_load = 1'b1;
                end else begin
                    timer_run = 1'b1;
                    if (timer_last) begin
                        state_d = BLANK;
                        if (idx_q == 6'(N_PIX - 1)) begin
                            boundary = 1'b1;
                            idx_d    = '0;
                            row_d    = '0;
                            col_d    = '0;
`ifdef MATRIX_SCAN_BRIGHTNESS_EN
                            bright_d = BRIGHT;
`endif
                            if (shadow_full_q) begin
                                active_d      = shadow_q;
                                shadow_full_d = 1'b0;
                            end
                        end else begin
                            idx_d = idx_q + 6'd1;
                            if (col_q == 3'(N_COLS - 1)) begin
                                col_d = '0;
                                row_d = row_q + 3'd1;
                            end else begin
                                col_d = col_q + 3'd1;
                            end
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are a registered view of the current state, so pins lag the FSM by one cycle.
    always_comb begin
        sel_d        = '0;
        ipt_d        = 1'b0;
        frame_done_d = boundary;
        if (state_q == BLANK || state_q == DRIVE) begin
            sel_d = {sel_code(col_q), sel_code(row_q)};
        end
        if (state_q == DRIVE) begin
            ipt_d = active_q[idx_q] && (dwell_count < on_threshold);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            row_q         <= '0;
            col_q         <= '0;
            // NOTE: the frame buffers are plain registers and are cleared so a reset frame is dark.
            active_q      <= '0;
            shadow_q      <= '0;
            shadow_full_q <= 1'b0;
            ipt_q         <= 1'b0;
            sel_q         <= '0;
            frame_done_q  <= 1'b0;
`ifdef MATRIX_SCAN_BRIGHTNESS_EN
            bright_q      <= '0;
`endif
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            row_q         <= row_d;
            col_q         <= col_d;
            active_q      <= active_d;
            shadow_q      <= shadow_d;
            shadow_full_q <= shadow_full_d;
            ipt_q         <= ipt_d;
            sel_q         <= sel_d;
            frame_done_q  <= frame_done_d;
`ifdef MATRIX_SCAN_BRIGHTNESS_EN
            bright_q      <= bright_d;
`endif
        end
    end

    assign LOAD_READY = ~shadow_full_q;
    assign IPT        = ipt_q;
    assign FRAME_DONE = frame_done_q;
    assign {SEL0, SEL1, SEL2, SEL3, SEL4, SEL5} = sel_q;

endmodule

// File: tb/tb_matrix_scan_controller.sv
// Self-checking bench: random and directed stimulus against a frame-timing reference model.
module tb_matrix_scan_controller;

    localparam int DWELL = 4;
    localparam int PER   = DWELL + 1;
    localparam int FRAME = 35 * PER;

    logic        clk = 1'b0;
    logic        rst = 1'b1, en = 1'b0, lv = 1'b0;
    logic [34:0] ld = '0;
    logic        LOAD_READY, IPT, FRAME_DONE;
    logic        SEL0, SEL1, SEL2, SEL3, SEL4, SEL5;
    logic [5:0]  sel;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    // Reference model: scan position is the cycle count since leaving IDLE.
    logic        m_run = 1'b0;
    int          m_t = 0;
    logic [34:0] m_active = '0, m_shadow = '0;
    logic        m_full = 1'b0;

    matrix_scan_controller #(.DWELL_CYCLES(DWELL)) dut (
        .CLK        (clk),
        .RST        (rst),
`ifdef MATRIX_SCAN_BRIGHTNESS_EN
        .BRIGHT     (4'hF),
`endif
        .ENABLE     (en),
        .LOAD_VALID (lv),
        .LOAD_DATA  (ld),
        .LOAD_READY (LOAD_READY),
        .IPT        (IPT),
        .SEL0       (SEL0),
        .SEL1       (SEL1),
        .SEL2       (SEL2),
        .SEL3       (SEL3),
        .SEL4       (SEL4),
        .SEL5       (SEL5),
        .FRAME_DONE (FRAME_DONE)
    );

    assign sel = {SEL0, SEL1, SEL2, SEL3, SEL4, SEL5};

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h expected=%0h cycle=%0d", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        logic [5:0]  e_sel;
        logic        e_ipt, e_fd, old_full;
        logic [34:0] old_shadow;
        int          pos, pix;
        @(posedge clk);
        cyc++;
        e_sel = '0;
        e_ipt = 1'b0;
        e_fd  = 1'b0;
        if (!rst && m_run) begin
            pos   = m_t % FRAME;
            pix   = pos / PER;
            e_sel = {3'(pix % 5 + 1), 3'(pix / 5 + 1)};
            e_ipt = (pos % PER != 0) && m_active[pix];
            e_fd  = en && (pos == FRAME - 1);
        end
        if (rst) begin
            m_run = 1'b0; m_t = 0; m_active = '0; m_shadow = '0; m_full = 1'b0;
        end else begin
            old_full   = m_full;
            old_shadow = m_shadow;
            if (lv && !old_full) begin
                m_shadow = ld;
                m_full   = 1'b1;
            end
            if (!m_run) begin
                if (old_full) begin
                    m_active = old_shadow;
                    m_full   = 1'b0;
                end
                if (en) begin
                    m_run = 1'b1;
                    m_t   = 0;
                end
            end else if (!en) begin
                m_run = 1'b0;
                m_t   = 0;
            end else begin
                if ((m_t % FRAME == FRAME - 1) && old_full) begin
                    m_active = old_shadow;
                    m_full   = 1'b0;
                end
                m_t++;
            end
        end
        #1;
        check("sel", 64'(sel), 64'(e_sel));
        check("ipt", 64'(IPT), 64'(e_ipt));
        check("frame_done", 64'(FRAME_DONE), 64'(e_fd));
        check("load_ready", 64'(LOAD_READY), 64'(!m_full));
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int n_hi, n_fd, fd_first, fd_gap;

        // Reset, then idle with ENABLE low.
        ticks(2);
        rst = 1'b0;
        ticks(5);
        check("idle_sel", 64'(sel), 64'd0);
        check("idle_ready", 64'(LOAD_READY), 64'd1);

        // Single lit pixel at row 0, column 0.
        lv = 1'b1; ld = 35'h1;
        tick();
        lv = 1'b0;
        ticks(2);
        en = 1'b1;
        n_hi = 0; n_fd = 0; fd_first = 0; fd_gap = 0;
        for (int i = 0; i < 360; i++) begin
            tick();
            if (i < 350 && IPT) begin
                n_hi++;
                check("p0_sel", 64'(sel), 64'h09);
            end
            if (FRAME_DONE) begin
                if (n_fd == 0) fd_first = i;
                else fd_gap = i - fd_first;
                n_fd++;
            end
        end
        check("p0_on_cycles", 64'(n_hi), 64'd8);
        check("fd_count", 64'(n_fd), 64'd2);
        check("fd_period", 64'(fd_gap), 64'(FRAME));

        // Last pixel: column 5, row 7.
        en = 1'b0;
        ticks(3);
        lv = 1'b1; ld = 35'h1 << 34;
        tick();
        lv = 1'b0;
        ticks(2);
        en = 1'b1;
        n_hi = 0;
        for (int i = 0; i < 180; i++) begin
            tick();
            if (IPT) begin
                n_hi++;
                check("p34_sel", 64'(sel), 64'h2F);
            end
        end
        check("p34_on_cycles", 64'(n_hi), 64'd4);

        // Double buffering: all-ones pending mid-frame, second offer held off.
        ticks(80);
        lv = 1'b1; ld = '1;
        tick();
        check("db_ready_low", 64'(LOAD_READY), 64'd0);
        ld = 35'h2AAAAAAAA;
        ticks(20);
        lv = 1'b0;
        ticks(120);
        n_hi = 0;
        for (int i = 0; i < FRAME; i++) begin
            tick();
            if (IPT) n_hi++;
        end
        check("db_all_on", 64'(n_hi), 64'(35 * DWELL));

        // Disable at pixel 17, then restart from pixel 0.
        en = 1'b0;
        ticks(3);
        en = 1'b1;
        ticks(87);
        en = 1'b0;
        ticks(2);
        check("dis_sel", 64'(sel), 64'd0);
        check("dis_ipt", 64'(IPT), 64'd0);
        tick();
        en = 1'b1;
        ticks(2);
        check("reen_sel", 64'(sel), 64'h09);

        // Reset mid-scan with a pending frame.
        ticks(50);
        lv = 1'b1; ld = 35'h555555555;
        tick();
        lv = 1'b0;
        ticks(10);
        rst = 1'b1;
        tick();
        check("rst_ready", 64'(LOAD_READY), 64'd1);
        check("rst_sel", 64'(sel), 64'd0);
        rst = 1'b0;
        n_hi = 0;
        for (int i = 0; i < 180; i++) begin
            tick();
            if (IPT) n_hi++;
        end
        check("rst_dark", 64'(n_hi), 64'd0);

        // Randomized traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            en  = ($urandom_range(0, 199) != 0) ? 1'b1 : ($urandom_range(0, 1) == 1);
            lv  = ($urandom_range(0, 7) == 0);
            ld  = {3'($urandom), 32'($urandom)};
            rst = ($urandom_range(0, 599) == 0);
            tick();
        end
        rst = 1'b0;
        lv  = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
